// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arith/compare ops; shifts iterate one bit per cycle.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b01010;
    localparam logic [4:0] ALU_OR   = 5'b01011;
    localparam logic [4:0] ALU_AND  = 5'b01100;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b01110;
    localparam logic [4:0] ALU_SRA  = 5'b01111;
    localparam logic [4:0] ALU_SLT  = 5'b10000;
    localparam logic [4:0] ALU_SLTU = 5'b10001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_t;

    state_t          state_q, state_d;
    shift_t          shift_type_q, shift_type_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SW-1:0]   shift_cnt_q, shift_cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] work_shifted;
    logic [SW-1:0]   shamt;
    logic            is_shift;
    shift_t          req_shift_type;

    assign shamt = op_b[SW-1:0];

    // Unknown codes fall through to ADD.
    always_comb begin
        alu_res = op_a + op_b;
        unique case (alu_ctrl)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = op_a + op_b;
        endcase
    end

    always_comb begin
        is_shift       = 1'b0;
        req_shift_type = SH_LL;
        unique case (alu_ctrl)
            ALU_SLL: begin
                is_shift       = 1'b1;
                req_shift_type = SH_LL;
            end
            ALU_SRL: begin
                is_shift       = 1'b1;
                req_shift_type = SH_RL;
            end
            ALU_SRA: begin
                is_shift       = 1'b1;
                req_shift_type = SH_RA;
            end
            default: begin
                is_shift       = 1'b0;
                req_shift_type = SH_LL;
            end
        endcase
    end

    always_comb begin
        work_shifted = {work_q[XLEN-2:0], 1'b0};
        unique case (shift_type_q)
            SH_RL:   work_shifted = {1'b0, work_q[XLEN-1:1]};
            SH_RA:   work_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default: work_shifted = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    // The last shift step writes the result directly so the total latency is shamt+1.
    always_comb begin
        state_d      = state_q;
        shift_type_d = shift_type_q;
        work_d       = work_q;
        shift_cnt_d  = shift_cnt_q;
        result_d     = result_q;
        zero_d       = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d       = op_a;
                        shift_cnt_d  = shamt;
                        shift_type_d = req_shift_type;
                        state_d      = SHIFT;
                    end else begin
                        result_d = is_shift ? op_a : alu_res;
                        zero_d   = (result_d == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d      = work_shifted;
                shift_cnt_d = shift_cnt_q - 1'b1;
                if (shift_cnt_q == SW'(1)) begin
                    result_d = work_shifted;
                    zero_d   = (work_shifted == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_type_q <= SH_LL;
            work_q       <= '0;
            shift_cnt_q  <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_type_q <= shift_type_d;
            work_q       <= work_d;
            shift_cnt_q  <= shift_cnt_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int testsRun;
    int testsFailed;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one op, waits for its result, and consumes it if out_ready is high.
    task automatic applyStimulus(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic zf, output int lat,
                                 output logic stallOk);
        int waitCnt;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (!in_ready) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        stallOk  = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) stallOk = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) checkOutput("result_timeout", {31'b0, out_valid}, 32'd1);
        res = result;
        zf  = zero;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic        zf;
        int          lat;
        logic        stallOk;
        logic [31:0] held;

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_ctrl    = 5'b0;
        op_a        = 32'h0;
        op_b        = 32'h0;
        out_ready   = 1'b1;

        #12;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", {31'b0, zero}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(5'b00000, 32'd5, 32'd7, res, zf, lat, stallOk);
        checkOutput("add_result", res, 32'd12);
        checkOutput("add_zero", {31'b0, zf}, 32'd0);
        checkOutput("add_latency", lat, 32'd1);
        checkOutput("add_back_idle", {31'b0, in_ready}, 32'd1);

        applyStimulus(5'b00001, 32'h10, 32'h10, res, zf, lat, stallOk);
        checkOutput("sub_eq_result", res, 32'd0);
        checkOutput("sub_eq_zero", {31'b0, zf}, 32'd1);

        applyStimulus(5'b00001, 32'h0, 32'h1, res, zf, lat, stallOk);
        checkOutput("sub_wrap_result", res, 32'hFFFF_FFFF);
        checkOutput("sub_wrap_zero", {31'b0, zf}, 32'd0);

        applyStimulus(5'b10011, 32'd3, 32'd4, res, zf, lat, stallOk);
        checkOutput("undef_is_add", res, 32'd7);

        applyStimulus(5'b01111, 32'h8000_0000, 32'h24, res, zf, lat, stallOk);
        checkOutput("sra_result", res, 32'hF800_0000);
        checkOutput("sra_latency", lat, 32'd5);
        checkOutput("sra_stall", {31'b0, stallOk}, 32'd1);

        applyStimulus(5'b01101, 32'h0000_ABCD, 32'h0, res, zf, lat, stallOk);
        checkOutput("sll0_result", res, 32'h0000_ABCD);
        checkOutput("sll0_latency", lat, 32'd1);

        applyStimulus(5'b01101, 32'h1, 32'h3, res, zf, lat, stallOk);
        checkOutput("sll3_result", res, 32'h8);
        checkOutput("sll3_latency", lat, 32'd4);

        applyStimulus(5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, res, zf, lat, stallOk);
        checkOutput("srl31_result", res, 32'h1);
        checkOutput("srl31_latency", lat, 32'd32);

        applyStimulus(5'b01110, 32'h1, 32'h1, res, zf, lat, stallOk);
        checkOutput("srl_to_zero_result", res, 32'h0);
        checkOutput("srl_to_zero_flag", {31'b0, zf}, 32'd1);

        applyStimulus(5'b10000, 32'hFFFF_FFFF, 32'h1, res, zf, lat, stallOk);
        checkOutput("slt_result", res, 32'd1);

        applyStimulus(5'b10001, 32'hFFFF_FFFF, 32'h1, res, zf, lat, stallOk);
        checkOutput("sltu_result", res, 32'd0);
        checkOutput("sltu_zero", {31'b0, zf}, 32'd1);

        applyStimulus(5'b01010, 32'hF0F0_1234, 32'h0FF0_1234, res, zf, lat, stallOk);
        checkOutput("xor_result", res, 32'hFF00_0000);

        applyStimulus(5'b01011, 32'h0F00_00A0, 32'h00F0_000B, res, zf, lat, stallOk);
        checkOutput("or_result", res, 32'h0FF0_00AB);

        // Backpressure: a pending op must not be taken while a result waits.
        out_ready = 1'b0;
        applyStimulus(5'b00000, 32'd1, 32'd2, res, zf, lat, stallOk);
        checkOutput("bp_first_result", res, 32'd3);
        held     = result;
        alu_ctrl = 5'b01010;
        op_a     = 32'hAAAA_0000;
        op_b     = 32'h0000_5555;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_result_stable", result, held);
            checkOutput("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_out_valid_high", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_released_idle", {31'b0, in_ready}, 32'd1);
        checkOutput("bp_released_valid", {31'b0, out_valid}, 32'd0);
        applyStimulus(5'b01010, 32'hAAAA_0000, 32'h0000_5555, res, zf, lat, stallOk);
        checkOutput("bp_new_op_result", res, 32'hAAAA_5555);

        // Reset in the middle of a long shift discards the partial result.
        alu_ctrl = 5'b01101;
        op_a     = 32'h1;
        op_b     = 32'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("midrst_busy_before", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        applyStimulus(5'b01100, 32'h0000_F0F0, 32'h0000_FF00, res, zf, lat, stallOk);
        checkOutput("post_rst_and", res, 32'h0000_F000);
        checkOutput("post_rst_and_lat", lat, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
